conv_layer_stream: RTL

Streaming 2-D convolution layer: the parametrised successor to the first-generation fixed conv1 path. It accepts one raster-order pixel per handshake and slides a KERNEL_SIZE×KERNEL_SIZE window with configurable stride. Each window produces NUM_OUTPUTS channel results through a pipelined multiply/adder tree with runtime-loadable signed weights and biases, requantisation, and saturation. It sits between the image source and the pooling stage, and adds valid/ready back-pressure the previous block lacked.

---
 rtl/conv_pkg.sv | 35 +++
 rtl/conv_line_buffer.sv | 49 ++++
 rtl/conv_layer_stream.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the streaming convolution layer: accumulator
// sizing, coefficient address layout and output saturation.
// CONV_RELU_EN selects unsigned ReLU-style clamping instead of signed clamping.
package conv_pkg;

  // Weights start at address 0; biases follow all NUM_OUTPUTS*K*K weights.
  localparam int WEIGHT_BASE = 0;

  function automatic int bias_base(input int num_outputs, input int k);
    return WEIGHT_BASE + num_outputs * k * k;
  endfunction

  // Wide enough for K*K unsigned-by-signed products plus a bias.
  function automatic int acc_bits(input int data_bits, input int weight_bits, input int k);
    return data_bits + weight_bits + $clog2(k * k) + 1;
  endfunction

  // Clamp a (sign-extended) shifted accumulator into the OUT_BITS result range.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] r,
                                                  input int out_bits);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
`ifdef CONV_RELU_EN
    hi = (64'sd1 <<< out_bits) - 64'sd1;
    lo = 64'sd0;
`else
    hi = (64'sd1 <<< (out_bits - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
`endif
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// K-1 row pixel FIFO plus the KxK window registers. On every advance the
// incoming pixel and the pixels above it in the same column shift into the
// right-hand window column; window[ky][kx] pairs with weight (ky,kx).
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int WIDTH  = 28,
  parameter int K      = 5,
  parameter int CW     = 5
) (
  input  logic                     clk,
  input  logic                     advance,
  input  logic                     stall,
  input  logic [CW-1:0]            col,
  input  logic [DATA_W-1:0]        pix,
  output logic [K*K*DATA_W-1:0]    window
);

  // lb[j][x] holds the pixel of column x from K-1-j rows above the current row.
  logic [DATA_W-1:0] lb  [K-1][WIDTH];
  logic [DATA_W-1:0] win [K][K];
  logic [DATA_W-1:0] tap [K];

  // Column of K vertically stacked pixels ending at the incoming one.
  always_comb begin
    tap[K-1] = pix;
    for (int j = 0; j < K - 1; j++) tap[j] = lb[j][col];
  end

  // Stage 1: rotate the column into the row FIFO and shift the window left.
  always_ff @(posedge clk) begin
    if (advance && !stall) begin
      for (int j = 0; j < K - 1; j++) lb[j][col] <= tap[j+1];
      for (int ky = 0; ky < K; ky++) begin
        for (int kx = 0; kx < K - 1; kx++) win[ky][kx] <= win[ky][kx+1];
        win[ky][K-1] <= tap[ky];
      end
    end
  end

  // Flatten the window so that tap index ky*K+kx matches the weight layout.
  always_comb begin
    for (int ky = 0; ky < K; ky++)
      for (int kx = 0; kx < K; kx++)
        window[(ky*K+kx)*DATA_W +: DATA_W] = win[ky][kx];
  end

endmodule

// File: rtl/conv_layer_stream.sv
// Streaming KxK convolution with stride, NUM_OUTPUTS channels, loadable
// signed weights/biases, requantising shift and saturation, and valid/ready
// flow control. Define CONV_RELU_EN for unsigned ReLU clamping of results.
module conv_layer_stream
  import conv_pkg::*;
#(
  parameter int WIDTH       = 28,
  parameter int HEIGHT      = 28,
  parameter int DATA_BITS   = 8,
  parameter int KERNEL_SIZE = 5,
  parameter int NUM_OUTPUTS = 3,
  parameter int STRIDE      = 1,
  parameter int WEIGHT_BITS = 8,
  parameter int OUT_BITS    = 12,
  parameter int SHIFT       = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_BITS-1:0]                in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NUM_OUTPUTS*OUT_BITS-1:0]     out_data,
  output logic                                frame_done,
  input  logic                                w_we,
  input  logic [$clog2(NUM_OUTPUTS*(KERNEL_SIZE*KERNEL_SIZE+1))-1:0] w_addr,
  input  logic signed [WEIGHT_BITS-1:0]       w_data
);

  localparam int K2        = KERNEL_SIZE * KERNEL_SIZE;
  localparam int NCOEF     = NUM_OUTPUTS * (K2 + 1);
  localparam int BIAS_BASE = bias_base(NUM_OUTPUTS, KERNEL_SIZE);
  localparam int ACC_BITS  = acc_bits(DATA_BITS, WEIGHT_BITS, KERNEL_SIZE);
  localparam int PW        = DATA_BITS + WEIGHT_BITS + 1;
  localparam int CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW        = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int LAST_COL  = KERNEL_SIZE - 1 + ((WIDTH - KERNEL_SIZE) / STRIDE) * STRIDE;
  localparam int LAST_ROW  = KERNEL_SIZE - 1 + ((HEIGHT - KERNEL_SIZE) / STRIDE) * STRIDE;

  logic                         stall;
  logic                         accept;
  logic [CW-1:0]                col;
  logic [RW-1:0]                row;
  logic                         win_ok;
  logic                         win_last;
  logic [K2*DATA_BITS-1:0]      window;
  logic signed [WEIGHT_BITS-1:0] coef [NCOEF];

  logic                         vld_p1, last_p1;
  logic                         vld_p2, last_p2;
  logic                         vld_p3, last_p3;
  logic signed [PW-1:0]         prod_p2 [NUM_OUTPUTS][K2];
  logic signed [ACC_BITS-1:0]   acc_sum [NUM_OUTPUTS];
  logic signed [ACC_BITS-1:0]   acc_p3  [NUM_OUTPUTS];

  // The whole pipeline freezes while a result waits for the consumer.
  always_comb begin
    stall    = out_valid && !out_ready;
    in_ready = !stall;
    accept   = in_valid && in_ready;
  end

  // Window validity of the pixel being accepted (its position is col,row).
  always_comb begin
    win_ok   = 1'b0;
    win_last = 1'b0;
    if (int'(col) >= KERNEL_SIZE - 1 && int'(row) >= KERNEL_SIZE - 1)
      win_ok = ((int'(col) - (KERNEL_SIZE - 1)) % STRIDE == 0) &&
               ((int'(row) - (KERNEL_SIZE - 1)) % STRIDE == 0);
    win_last = (int'(col) == LAST_COL) && (int'(row) == LAST_ROW);
  end

  // Raster position counters; wrap at frame end with no idle cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == CW'(WIDTH - 1)) begin
        col <= '0;
        row <= (row == RW'(HEIGHT - 1)) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Coefficient store; addresses beyond the bias block are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCOEF; i++) coef[i] <= '0;
    end else if (w_we && int'(w_addr) < NCOEF) begin
      coef[w_addr] <= w_data;
    end
  end

  conv_line_buffer #(
    .DATA_W (DATA_BITS),
    .WIDTH  (WIDTH),
    .K      (KERNEL_SIZE),
    .CW     (CW)
  ) u_line_buffer (
    .clk     (clk),
    .advance (accept),
    .stall   (stall),
    .col     (col),
    .pix     (in_data),
    .window  (window)
  );

  // Valid/last tags travelling alongside the data stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      last_p1    <= 1'b0;
      vld_p2     <= 1'b0;
      last_p2    <= 1'b0;
      vld_p3     <= 1'b0;
      last_p3    <= 1'b0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else if (!stall) begin
      vld_p1     <= accept && win_ok;
      last_p1    <= accept && win_ok && win_last;
      vld_p2     <= vld_p1;
      last_p2    <= last_p1;
      vld_p3     <= vld_p2;
      last_p3    <= last_p2;
      out_valid  <= vld_p3;
      frame_done <= vld_p3 && last_p3;
    end
  end

  // Stage 2: zero-extended pixel times signed weight.
  always_ff @(posedge clk) begin
    if (!stall) begin
      for (int c = 0; c < NUM_OUTPUTS; c++)
        for (int i = 0; i < K2; i++)
          prod_p2[c][i] <= PW'($signed({1'b0, window[i*DATA_BITS +: DATA_BITS]})) *
                           PW'(coef[c*K2 + i]);
    end
  end

  // Adder tree per channel, seeded with the sign-extended bias.
  always_comb begin
    for (int c = 0; c < NUM_OUTPUTS; c++) begin
      acc_sum[c] = ACC_BITS'(coef[BIAS_BASE + c]);
      for (int i = 0; i < K2; i++) acc_sum[c] = acc_sum[c] + ACC_BITS'(prod_p2[c][i]);
    end
  end

  // Stage 3: registered channel sums.
  always_ff @(posedge clk) begin
    if (!stall) begin
      for (int c = 0; c < NUM_OUTPUTS; c++) acc_p3[c] <= acc_sum[c];
    end
  end

  // Stage 4: requantise and saturate; held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
    end else if (!stall && vld_p3) begin
      for (int c = 0; c < NUM_OUTPUTS; c++)
        out_data[c*OUT_BITS +: OUT_BITS] <=
          OUT_BITS'(saturate(64'(acc_p3[c] >>> SHIFT), OUT_BITS));
    end
  end

endmodule
